// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Purpose : Opcode encodings and the opcode type shared by the ALU core
//           and the two-requester ALU arbiter.
// Contents: ALU_WIDTH     - datapath width (only 32 is supported)
//           OPC_*         - raw 3-bit opcode encodings
//           alu_op_e      - enumerated opcode type built from OPC_*
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] OPC_ADD  = 3'b000;
    localparam logic [2:0] OPC_SUB  = 3'b001;
    localparam logic [2:0] OPC_AND  = 3'b010;
    localparam logic [2:0] OPC_OR   = 3'b011;
    localparam logic [2:0] OPC_XOR  = 3'b100;
    localparam logic [2:0] OPC_SLT  = 3'b101;
    localparam logic [2:0] OPC_RSV6 = 3'b110;
    localparam logic [2:0] OPC_RSV7 = 3'b111;

    typedef enum logic [2:0] {
        OP_ADD  = OPC_ADD,
        OP_SUB  = OPC_SUB,
        OP_AND  = OPC_AND,
        OP_OR   = OPC_OR,
        OP_XOR  = OPC_XOR,
        OP_SLT  = OPC_SLT,
        OP_RSV6 = OPC_RSV6,
        OP_RSV7 = OPC_RSV7
    } alu_op_e;

endpackage

// File: rtl/alu32_core.sv
// ---------------------------------------------------------------------------
// alu32_core
// Purpose : Purely combinational 32-bit ALU.
// Ports   : op        in  opcode (alu_op_e)
//           a, b      in  32-bit operands
//           result    out 32-bit result
//           carryout  out carry out of bit 31 (ADD/SUB only)
//           overflow  out signed overflow (ADD/SUB only)
// ---------------------------------------------------------------------------
module alu32_core
    import alu_pkg::*;
(
    input  alu_op_e               op,
    input  logic [ALU_WIDTH-1:0]  a,
    input  logic [ALU_WIDTH-1:0]  b,
    output logic [ALU_WIDTH-1:0]  result,
    output logic                  carryout,
    output logic                  overflow
);

    logic [ALU_WIDTH:0] w_sum;
    logic [ALU_WIDTH:0] w_diff;
    logic               w_addOvf;
    logic               w_subOvf;

    // Subtraction is a + ~b + 1 so its bit-32 carry is the "no borrow" flag;
    // SLT reuses the same difference and overflow to get a signed compare.
    always_comb begin
        w_sum    = {1'b0, a} + {1'b0, b};
        w_diff   = {1'b0, a} + {1'b0, ~b} + {{ALU_WIDTH{1'b0}}, 1'b1};
        w_addOvf = (a[ALU_WIDTH-1] == b[ALU_WIDTH-1]) &&
                   (w_sum[ALU_WIDTH-1] != a[ALU_WIDTH-1]);
        w_subOvf = (a[ALU_WIDTH-1] != b[ALU_WIDTH-1]) &&
                   (w_diff[ALU_WIDTH-1] != a[ALU_WIDTH-1]);
    end

    always_comb begin
        result   = '0;
        carryout = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                result   = w_sum[ALU_WIDTH-1:0];
                carryout = w_sum[ALU_WIDTH];
                overflow = w_addOvf;
            end
            OP_SUB: begin
                result   = w_diff[ALU_WIDTH-1:0];
                carryout = w_diff[ALU_WIDTH];
                overflow = w_subOvf;
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SLT: result = {{(ALU_WIDTH-1){1'b0}}, w_diff[ALU_WIDTH-1] ^ w_subOvf};
            default: begin
                result   = '0;
                carryout = 1'b0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Purpose : Shares one 32-bit ALU between two requesters with round-robin
//           arbitration and a single-entry response register (latency 1,
//           one op per cycle when the consumer is always ready).
// Ports   : clk, reset_n              clock, synchronous active-low reset
//           req_valid[1:0]            per-requester operation present
//           req_ready[1:0]            per-requester accept (one-hot or 00)
//           req_op0/1, req_a0/1, req_b0/1   per-requester opcode/operands
//           rsp_valid / rsp_ready     response handshake
//           rsp_result, rsp_id        result and issuing requester
//           rsp_carryout, rsp_overflow  ALU flags
// ---------------------------------------------------------------------------
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2:0]       req_op0,
    input  logic [2:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_id,
    output logic             rsp_carryout,
    output logic             rsp_overflow
);

    logic             r_lastGrant;
    logic             r_rspValid;
    logic [WIDTH-1:0] r_rspResult;
    logic             r_rspId;
    logic             r_rspCarry;
    logic             r_rspOvf;

    logic             w_slotFree;
    logic             w_grant;
    logic             w_accept;
    alu_op_e          w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_ovf;

    // Grant depends only on valids, the pointer and the response slot, so
    // operand values never reach req_ready. On a tie the requester that did
    // not win last time goes next.
    always_comb begin
        w_slotFree = !r_rspValid || rsp_ready;
        w_grant    = (req_valid == 2'b11) ? ~r_lastGrant : req_valid[1];
        req_ready  = 2'b00;
        if (reset_n && w_slotFree && (req_valid != 2'b00)) begin
            req_ready = w_grant ? 2'b10 : 2'b01;
        end
        w_accept = |(req_valid & req_ready);
        w_op     = alu_op_e'(w_grant ? req_op1 : req_op0);
        w_a      = w_grant ? req_a1 : req_a0;
        w_b      = w_grant ? req_b1 : req_b0;
    end

    alu32_core u_alu (
        .op       (w_op),
        .a        (w_a),
        .b        (w_b),
        .result   (w_result),
        .carryout (w_carry),
        .overflow (w_ovf)
    );

    // An accept overwrites the slot even in the cycle it drains, which is
    // what gives back-to-back throughput; a drain without an accept just
    // clears valid and leaves the last payload in place.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rspValid  <= 1'b0;
            r_rspResult <= '0;
            r_rspId     <= 1'b0;
            r_rspCarry  <= 1'b0;
            r_rspOvf    <= 1'b0;
            r_lastGrant <= 1'b1;
        end else if (w_accept) begin
            r_rspValid  <= 1'b1;
            r_rspResult <= w_result;
            r_rspId     <= w_grant;
            r_rspCarry  <= w_carry;
            r_rspOvf    <= w_ovf;
            r_lastGrant <= w_grant;
        end else if (rsp_ready) begin
            r_rspValid  <= 1'b0;
        end
    end

    assign rsp_valid    = r_rspValid;
    assign rsp_result   = r_rspResult;
    assign rsp_id       = r_rspId;
    assign rsp_carryout = r_rspCarry;
    assign rsp_overflow = r_rspOvf;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
// Purpose : Self-checking bench for alu_share_arbiter. A behavioural model
//           (signed/unsigned arithmetic plus a simple response-slot model)
//           predicts req_ready every cycle and the response after every edge.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [2:0]  req_op0, req_op1;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_id;
    logic        rsp_carryout;
    logic        rsp_overflow;

    int vectors;
    int miscompares;

    // Reference model state
    logic        mValid;
    logic [31:0] mResult;
    logic        mId;
    logic        mCarry;
    logic        mOvf;
    logic        mLast;
    logic        mJustReset;

    alu_share_arbiter #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op0      (req_op0),
        .req_op1      (req_op1),
        .req_a0       (req_a0),
        .req_b0       (req_b0),
        .req_a1       (req_a1),
        .req_b1       (req_b1),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_id       (rsp_id),
        .rsp_carryout (rsp_carryout),
        .rsp_overflow (rsp_overflow)
    );

    // Free-running 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference written from the opcode definitions
    function automatic void refAlu(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] res,
                                   output logic co, output logic ov);
        longint sa, sb, s;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = 32'd0;
        co  = 1'b0;
        ov  = 1'b0;
        case (op)
            3'd0: begin
                res = a + b;
                co  = ((ua + ub) > 64'h0000_0000_FFFF_FFFF);
                s   = sa + sb;
                ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                res = a - b;
                co  = (ua >= ub);
                s   = sa - sb;
                ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = (sa < sb) ? 32'd1 : 32'd0;
            default: res = 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Response side: compared after every edge; payload only when it matters
    task automatic checkOutput();
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, mValid});
        if (mValid || mJustReset) begin
            check("rsp_result",   rsp_result, mResult);
            check("rsp_id",       {31'd0, rsp_id}, {31'd0, mId});
            check("rsp_carryout", {31'd0, rsp_carryout}, {31'd0, mCarry});
            check("rsp_overflow", {31'd0, rsp_overflow}, {31'd0, mOvf});
        end
    endtask

    // One cycle: drive inputs, check req_ready, clock, update model, check outputs
    task automatic applyStimulus(input logic rn, input logic [1:0] v,
                                 input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                                 input logic rr);
        logic [1:0]  expReady;
        logic        g;
        logic [31:0] res;
        logic        co, ov;
        reset_n   = rn;
        req_valid = v;
        req_op0   = op0; req_a0 = a0; req_b0 = b0;
        req_op1   = op1; req_a1 = a1; req_b1 = b1;
        rsp_ready = rr;
        #1;
        g = (v == 2'b11) ? ~mLast : v[1];
        if (!rn || (mValid && !rr) || v == 2'b00) expReady = 2'b00;
        else expReady = g ? 2'b10 : 2'b01;
        check("req_ready", {30'd0, req_ready}, {30'd0, expReady});
        vectors++;
        @(posedge clk);
        #1;
        mJustReset = 1'b0;
        if (!rn) begin
            mValid = 0; mResult = 0; mId = 0; mCarry = 0; mOvf = 0; mLast = 1;
            mJustReset = 1'b1;
        end else if (expReady != 2'b00) begin
            if (g) refAlu(op1, a1, b1, res, co, ov);
            else   refAlu(op0, a0, b0, res, co, ov);
            mValid = 1; mResult = res; mId = g; mCarry = co; mOvf = ov; mLast = g;
        end else if (rr) begin
            mValid = 0;
        end
        checkOutput();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mValid = 0; mResult = 0; mId = 0; mCarry = 0; mOvf = 0; mLast = 1; mJustReset = 0;
        reset_n = 0; req_valid = 0; rsp_ready = 0;
        req_op0 = 0; req_op1 = 0; req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
        @(posedge clk);
        #1;

        // Reset with requests pending: no grants, cleared response
        applyStimulus(0, 2'b11, 3'd0, 32'd1, 32'd2, 3'd0, 32'd3, 32'd4, 1);
        applyStimulus(0, 2'b11, 3'd0, 32'd1, 32'd2, 3'd0, 32'd3, 32'd4, 1);

        // Both valid, consumer ready: grants 0,1,0,1 and ids follow
        check("first_tie_grant", {30'd0, req_ready}, 32'd0);
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 2'b11, 3'd0, $urandom, $urandom, 3'd1, $urandom, $urandom, 1);
        check("alternate_id_last", {31'd0, rsp_id}, 32'd1);

        // SLT boundary: most negative < 1
        applyStimulus(1, 2'b01, 3'd5, 32'h8000_0000, 32'h0000_0001, 3'd0, 0, 0, 1);
        check("slt_boundary", rsp_result, 32'h0000_0001);

        // ADD signed overflow, SUB equal operands
        applyStimulus(1, 2'b10, 3'd0, 0, 0, 3'd0, 32'h7FFF_FFFF, 32'd1, 1);
        check("add_ovf_flag", {31'd0, rsp_overflow}, 32'd1);
        applyStimulus(1, 2'b10, 3'd0, 0, 0, 3'd1, 32'd5, 32'd5, 1);
        check("sub_eq_carry", {31'd0, rsp_carryout}, 32'd1);

        // Back-pressure: hold 3 cycles, then drain and accept together
        applyStimulus(1, 2'b11, 3'd2, $urandom, $urandom, 3'd3, $urandom, $urandom, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 2'b11, 3'd4, $urandom, $urandom, 3'd6, $urandom, $urandom, 0);
        applyStimulus(1, 2'b11, 3'd4, $urandom, $urandom, 3'd7, $urandom, $urandom, 1);
        applyStimulus(1, 2'b00, 3'd0, 0, 0, 3'd0, 0, 0, 1);

        // Reset while a response is held, then first tie goes to requester 0
        applyStimulus(1, 2'b01, 3'd0, 32'd9, 32'd9, 3'd0, 0, 0, 0);
        applyStimulus(0, 2'b00, 3'd0, 0, 0, 3'd0, 0, 0, 0);
        applyStimulus(1, 2'b11, 3'd1, $urandom, $urandom, 3'd0, $urandom, $urandom, 1);
        check("post_reset_tie_id", {31'd0, rsp_id}, 32'd0);

        // Randomized traffic with occasional back-pressure and resets
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a0r, a1r;
            a0r = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
            a1r = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            applyStimulus(($urandom_range(0, 99) != 0),
                          2'($urandom_range(0, 3)),
                          3'($urandom_range(0, 7)), a0r, $urandom,
                          3'($urandom_range(0, 7)), a1r, $urandom,
                          ($urandom_range(0, 9) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, datapath width; only 32 is supported.
REQ-002 The block SHALL have one clock and use synchronous, active-low reset, with ports as follows.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  synchronous active-low reset, sampled on clk.
REQ-005 req_valid  input  2  bit i: requester i presents an operation.
REQ-006 req_ready  output  2  bit i: requester i's operation is accepted this cycle.
REQ-007 req_op0, req_op1  input  3 each  opcode per requester.
REQ-008 req_a0, req_b0, req_a1, req_b1  input  32 each  operands per requester.
REQ-009 rsp_valid  output  1  the response register holds a result.
REQ-010 rsp_ready  input  1  the consumer takes the response this cycle.
REQ-011 rsp_result  output  32  ALU result.
REQ-012 rsp_id  output  1  index of the requester that issued the result.
REQ-013 rsp_carryout, rsp_overflow  output  1 each  ALU flags.

Function
REQ-014 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT; 110/111 reserved.
REQ-015 ADD SHALL produce a+b mod 2^32; carryout is the carry out of bit 31; overflow is the signed overflow.
REQ-016 SUB SHALL produce a+~b+1; carryout is the carry out of bit 31 (1 iff a>=b unsigned); overflow is the signed overflow.
REQ-017 SLT SHALL produce result[0] = diff[31] XOR sub_overflow with result[31:1]=0; carryout=0; overflow=0.
REQ-018 AND/OR/XOR SHALL be bitwise with both flags 0.
REQ-019 Reserved opcodes SHALL return result 0 and flags 0, and SHALL still complete a handshake.
REQ-020 slot_free = !rsp_valid || rsp_ready; at most one req_ready bit is high per cycle, and only while slot_free.
REQ-021 A request accepted in cycle N SHALL appear on rsp_* with rsp_valid=1 in cycle N+1 (latency 1).
REQ-022 With rsp_ready held at 1, throughput SHALL be one operation per cycle.
REQ-023 Arbitration SHALL be round-robin with a 1-bit last_grant pointer: if only one requester is valid, it wins; if both are valid, the non-last_grant requester wins.
REQ-024 last_grant SHALL update only on an actual handshake (req_valid[i] && req_ready[i]).
REQ-025 While rsp_valid && !rsp_ready, all rsp_* outputs SHALL hold stable and req_ready SHALL be 00.
REQ-026 A drain and a new accept in the same cycle SHALL replace the response register with no bubble.
REQ-027 When the slot drains with no request pending, rsp_valid SHALL fall to 0 in the next cycle.
REQ-028 req_ready SHALL be combinational from req_valid, last_grant, rsp_valid and rsp_ready only, never from operands.

Reset
REQ-029 While reset_n=0 at a clk edge, the block SHALL set rsp_valid=0, rsp_result=0, rsp_id=0, rsp_carryout=0, rsp_overflow=0 and last_grant=1, so requester 0 wins the first tie.
REQ-030 req_ready SHALL be 00 in any cycle where reset_n=0.
REQ-031 Reset asserted mid-operation SHALL discard the pending response; no response is emitted for it after reset releases.

Structure
REQ-032 Opcode localparams and the opcode typedef SHALL live in the shared package alu_pkg.
REQ-033 The combinational ALU SHALL be a sub-module alu32_core (inputs op, a, b; outputs result, carryout, overflow); the arbiter and the response register live in alu_share_arbiter.

Verification
REQ-034 Both requesters valid, rsp_ready=1, after reset -> grants alternate 0,1,0,1; rsp_id follows the same sequence one cycle later.
REQ-035 Requester 0 SLT with a=0x80000000, b=0x00000001 -> rsp_result=0x00000001, rsp_carryout=0, rsp_overflow=0.
REQ-036 Requester 1 ADD with a=0x7FFFFFFF, b=1 -> rsp_result=0x80000000, rsp_overflow=1, rsp_carryout=0; SUB with a=5, b=5 -> result 0, rsp_carryout=1.
REQ-037 rsp_ready=0 for 3 cycles with both requesters valid -> req_ready=00, rsp_* stable; then rsp_ready=1 -> drain and a new accept happen in the same cycle.
REQ-038 reset_n driven low for 1 cycle while rsp_valid=1 -> rsp_valid=0 next cycle; the next tie is granted to requester 0.
